// File: rtl/memory_twos_complement_pkg.sv
// Shared types and the negation reference function for the two's-complement lookup memory.
package memory_twos_complement_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 5;
  localparam int unsigned DEFAULT_DATA_W = 5;

  typedef enum logic [0:0] {
    SEQ_INIT = 1'b0,
    SEQ_DONE = 1'b1
  } seq_state_e;

  // Arithmetic negation of value, kept to the low width bits.
  function automatic logic [31:0] neg_code(input logic [31:0] value, input int unsigned width);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (~value + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/memory_twos_complement_init_sequencer.sv
// Walks the table address space once after reset, producing one write per clock,
// then parks in SEQ_DONE until the next reset.
module tc_init_sequencer
  import memory_twos_complement_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output seq_state_e        state_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEQ_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter stops on the last entry so no further writes can occur.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == SEQ_INIT) begin
      if (cnt_q == LAST_ADDR) begin
        state_d = SEQ_DONE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    wr_en_o   = (state_q == SEQ_INIT);
    wr_addr_o = cnt_q;
    wr_data_o = DATA_W'(neg_code(32'(cnt_q), DATA_W));
    state_o   = state_q;
  end

endmodule

// File: rtl/memory_twos_complement.sv
// Self-filling lookup table that returns -addr (mod 2^DATA_W) with one clock of latency.
module memory_twos_complement
  import memory_twos_complement_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_out,
  output logic              ready
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  if (DATA_W != ADDR_W) begin : g_width_check
    $fatal(1, "memory_twos_complement: DATA_W must equal ADDR_W");
  end

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  seq_state_e        seq_state;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] data_out_q, data_out_d;

  tc_init_sequencer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_seq (
    .clk       (clk),
    .rst       (rst),
    .wr_en_o   (wr_en),
    .wr_addr_o (wr_addr),
    .wr_data_o (wr_data),
    .state_o   (seq_state)
  );

  // The sequencer's done state is itself a register, so ready rises on the
  // same edge that writes the final entry.
  assign ready = (seq_state == SEQ_DONE);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Forcing zero while not ready keeps an unknown addr out of data_out.
  always_comb begin
    data_out_d = '0;
    if (ready) begin
      data_out_d = mem_q[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_memory_twos_complement.sv
// Directed bench for memory_twos_complement: init timing, full sweep, back-to-back reads,
// mid-run reset, plus a running negation property whenever reads are enabled.
module tb_memory_twos_complement;
  import memory_twos_complement_pkg::*;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 5;

  logic          clk;
  logic          rst;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_out;
  logic          ready;

  int total = 0;
  int bad   = 0;

  memory_twos_complement #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data_out (data_out),
    .ready    (ready)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst  = 1'b1;
    addr = '0;
  end

  // Property: a read enabled at the last edge returns the negation of the addr sampled there.
  logic [AW-1:0] addr_at_edge;
  logic          ready_before_edge;
  logic          prop_en = 1'b0;

  always @(posedge clk) begin
    addr_at_edge      <= addr;
    ready_before_edge <= ready;
  end

  always @(negedge clk) begin
    logic [DW-1:0] sum;
    if (prop_en && ready === 1'b1 && ready_before_edge === 1'b1 && !$isunknown(addr_at_edge)) begin
      sum = data_out + DW'(addr_at_edge);
      total = total + 1;
      if (sum !== '0) begin
        bad = bad + 1;
        $display("FAIL prop_negation: addr=%0d data_out=0x%02h sum=0x%02h required 0x00",
                 addr_at_edge, data_out, sum);
      end
    end
  end

  // Advance one full clock; return at the falling edge where outputs are stable.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst  = 1'b1;
    addr = 5'd7;
    tick();
    tick();
    total = total + 1;
    if (ready !== 1'b0 || data_out !== 5'h00) begin
      bad = bad + 1;
      $display("FAIL reset_state: ready=%b data_out=0x%02h required ready=0 data_out=0x00", ready, data_out);
    end
  endtask

  // Release reset with addr=7 held; ready must appear exactly on the 32nd edge.
  task automatic test_init_timing();
    rst = 1'b0;
    prop_en = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      tick();
      total = total + 1;
      if (e < 32) begin
        if (ready !== 1'b0 || data_out !== 5'h00) begin
          bad = bad + 1;
          $display("FAIL init_hold edge %0d: ready=%b data_out=0x%02h required ready=0 data_out=0x00",
                   e, ready, data_out);
        end
      end else if (ready !== 1'b1) begin
        bad = bad + 1;
        $display("FAIL init_ready edge 32: ready=%b required 1", ready);
      end
    end
    tick();
    total = total + 1;
    if (data_out !== 5'h19) begin
      bad = bad + 1;
      $display("FAIL first_read addr=7: data_out=0x%02h required 0x19", data_out);
    end
  endtask

  task automatic test_sweep();
    logic [DW-1:0] exp_v;
    logic [DW-1:0] spot;
    for (int a = 0; a < 32; a++) begin
      addr = AW'(a);
      tick();
      exp_v = DW'(neg_code(32'(a), DW));
      total = total + 1;
      if (data_out !== exp_v) begin
        bad = bad + 1;
        $display("FAIL sweep addr=%0d: data_out=0x%02h required 0x%02h", a, data_out, exp_v);
      end
      spot = 5'h00;
      case (a)
        1:  spot = 5'h1F;
        5:  spot = 5'h1B;
        16: spot = 5'h10;
        31: spot = 5'h01;
        default: spot = 5'h00;
      endcase
      if (a == 0 || a == 1 || a == 5 || a == 16 || a == 31) begin
        total = total + 1;
        if (data_out !== spot) begin
          bad = bad + 1;
          $display("FAIL spot addr=%0d: data_out=0x%02h required 0x%02h", a, data_out, spot);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a_v [3];
    logic [DW-1:0] e_v [3];
    a_v[0] = 5'd3;  e_v[0] = 5'h1D;
    a_v[1] = 5'd3;  e_v[1] = 5'h1D;
    a_v[2] = 5'd12; e_v[2] = 5'h14;
    for (int i = 0; i < 3; i++) begin
      addr = a_v[i];
      tick();
      total = total + 1;
      if (data_out !== e_v[i]) begin
        bad = bad + 1;
        $display("FAIL back_to_back[%0d] addr=%0d: data_out=0x%02h required 0x%02h",
                 i, a_v[i], data_out, e_v[i]);
      end
    end
  endtask

  // One-cycle reset during reads, with addr unknown for part of the re-initialisation.
  task automatic test_reset_mid();
    addr = 5'd20;
    tick();
    total = total + 1;
    if (data_out !== 5'h0C) begin
      bad = bad + 1;
      $display("FAIL pre_reset addr=20: data_out=0x%02h required 0x0C", data_out);
    end
    rst = 1'b1;
    tick();
    total = total + 1;
    if (ready !== 1'b0 || data_out !== 5'h00) begin
      bad = bad + 1;
      $display("FAIL mid_reset: ready=%b data_out=0x%02h required ready=0 data_out=0x00", ready, data_out);
    end
    rst  = 1'b0;
    addr = 'x;
    for (int e = 1; e <= 32; e++) begin
      if (e == 17) addr = 5'd20;
      tick();
      total = total + 1;
      if (e < 32) begin
        if (ready !== 1'b0 || data_out !== 5'h00) begin
          bad = bad + 1;
          $display("FAIL reinit_hold edge %0d: ready=%b data_out=0x%02h required ready=0 data_out=0x00",
                   e, ready, data_out);
        end
      end else if (ready !== 1'b1) begin
        bad = bad + 1;
        $display("FAIL reinit_ready edge 32: ready=%b required 1", ready);
      end
    end
    tick();
    total = total + 1;
    if (data_out !== 5'h0C) begin
      bad = bad + 1;
      $display("FAIL post_reset addr=20: data_out=0x%02h required 0x0C", data_out);
    end
  endtask

  initial begin
    test_reset();
    test_init_timing();
    test_sweep();
    test_back_to_back();
    test_reset_mid();
    tick();
    prop_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past 200000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/memory_twos_complement.md
Name: memory_twos_complement

Overview:
- Lookup memory returning the two's complement (arithmetic negation, modulo 2^DATA_W) of its address.
- Serves the serial thermometer/binary-to-two's-complement converter in the partial-product adder path; a caller presents a magnitude as the address and receives its negated code.
- Holds an internal DEPTH x DATA_W table that the block fills itself after reset, then serves registered reads.

Parameters:
- ADDR_W, 5, address width; DEPTH = 2^ADDR_W entries (32 by default).
- DATA_W, 5, data width; must equal ADDR_W (elaboration-time check, fatal if different).

Ports:
- clk  input  1  rising-edge clock, only clock in the block.
- rst  input  1  synchronous, active-high reset.
- addr  input  ADDR_W  read address (unsigned magnitude).
- data_out  output  DATA_W  registered table entry for addr; two's-complement code of -addr.
- ready  output  1  high once table initialisation is complete; reads are valid only while high.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All state changes on the rising edge of clk.
- Reset (rst=1 at an edge):
  - init counter cleared to 0; ready <= 0; data_out <= 0.
  - Table contents are don't-care until rewritten.
- Initialisation, starting the first edge with rst=0:
  - At edge k (k = 0..DEPTH-1), write mem[k] <= (~k + 1) truncated to DATA_W bits.
  - On the edge that writes entry DEPTH-1, set ready <= 1. Ready is therefore high DEPTH edges after reset release (32 by default).
  - Counter then holds, with no further writes.
- Table content by default (hex, DATA_W=5):
  - 0->00, 1->1F, 2->1E, 15->11, 16->10, 17->0F, 31->01.
  - Entry 0 maps to 0. Entry 16 (most negative code) maps to itself.
- Read:
  - While ready=1, every edge does data_out <= mem[addr]. Latency is 1 clock from addr to data_out, with no enable and no handshake.
  - addr changes take effect at the next edge only. Combinational glitches on addr never reach data_out.
- While ready=0, data_out is held at 0 regardless of addr.
- Reset mid-initialisation or mid-read: on the same edge ready drops to 0 and data_out goes to 0. Initialisation restarts from entry 0 and takes the full DEPTH cycles again.
- Every addr value is legal, so there is no out-of-range case. X on addr while ready=0 must not propagate to data_out.
- No write port is exposed; contents are fixed by construction.

Decomposition:
- Shared package:
  - default ADDR_W/DATA_W constants (5);
  - a pure function neg_code(value, width) returning (~value + 1) masked to width, used by both RTL and bench as the reference model.
- One sub-module: tc_init_sequencer.
  - Holds the init counter and done flag.
  - Outputs write enable, write address and write data (neg_code of the address).
  - The top keeps the memory array, read register and ready output.

Test Plan:
- Assert rst 2 cycles, release -> ready=0 and data_out=0 for exactly 31 edges; ready=1 after the 32nd edge.
- After ready, sweep addr 0..31, one per cycle -> data_out one cycle later equals neg_code(addr). Spot values: 0->0x00, 1->0x1F, 5->0x1B, 16->0x10, 31->0x01.
- Drive addr=7 during initialisation -> data_out stays 0x00 until ready; first valid read gives 0x19.
- Apply addr 3,3,12 back-to-back -> data_out 0x1D,0x1D,0x14 with 1-cycle latency and no bubbles.
- Pulse rst for 1 cycle mid-sweep (addr=20) -> same edge ready=0 and data_out=0x00. After 32 more edges, ready=1 and addr=20 reads 0x0C.
- Property over the whole run: whenever ready=1, data_out + (addr from the prior cycle) = 0 mod 32.
